// File: rtl/shared_match_pe.sv
// Match engine: compares the byte streams at head_addr and history_addr one beat at a time.
// Returns the common-prefix length, capped at MAX_MATCH_LEN, together with the request tag.
module shared_match_pe #(
  parameter int ADDR_W        = 24,
  parameter int TAG_W         = 5,
  parameter int MATCH_LEN_W   = 8,
  parameter int MAX_MATCH_LEN = 255,
  parameter int BYTES         = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   match_req_valid,
  output logic                   match_req_ready,
  input  logic [ADDR_W-1:0]      match_req_head_addr,
  input  logic [ADDR_W-1:0]      match_req_history_addr,
  input  logic [TAG_W-1:0]       match_req_tag,
  output logic                   match_resp_valid,
  input  logic                   match_resp_ready,
  output logic [TAG_W-1:0]       match_resp_tag,
  output logic [MATCH_LEN_W-1:0] match_resp_match_len,
  output logic                   head_rd_en,
  output logic [ADDR_W-1:0]      head_rd_addr,
  input  logic [8*BYTES-1:0]     head_rd_data,
  output logic                   hist_rd_en,
  output logic [ADDR_W-1:0]      hist_rd_addr,
  input  logic [8*BYTES-1:0]     hist_rd_data
);

  localparam int EQ_W = $clog2(BYTES + 1);

  typedef enum logic [1:0] {IDLE, READ, CMP, RESP} state_t;

  state_t                 state;
  logic [ADDR_W-1:0]      head_q;
  logic [ADDR_W-1:0]      hist_q;
  logic [ADDR_W-1:0]      off_q;
  logic [EQ_W-1:0]        eq;
  logic                   found;
  logic [MATCH_LEN_W-1:0] eq_ext;
  logic [MATCH_LEN_W-1:0] rem;
  logic [MATCH_LEN_W-1:0] add;
  logic [MATCH_LEN_W-1:0] new_len;

  // Gated by rst_n because the async reset parks state in IDLE while reset is still asserted.
  assign match_req_ready = rst_n && (state == IDLE);

  // Leading run of equal bytes in the current beat; byte 0 is the lowest address.
  always_comb begin
    eq    = '0;
    found = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      if (!found) begin
        if (head_rd_data[8*i +: 8] == hist_rd_data[8*i +: 8]) begin
          eq = EQ_W'(i + 1);
        end else begin
          found = 1'b1;
        end
      end
    end
  end

  assign eq_ext  = MATCH_LEN_W'(eq);
  assign rem     = MATCH_LEN_W'(MAX_MATCH_LEN) - match_resp_match_len;
  assign add     = (eq_ext < rem) ? eq_ext : rem;
  assign new_len = match_resp_match_len + add;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      head_q               <= '0;
      hist_q               <= '0;
      off_q                <= '0;
      match_resp_valid     <= 1'b0;
      match_resp_tag       <= '0;
      match_resp_match_len <= '0;
      head_rd_en           <= 1'b0;
      hist_rd_en           <= 1'b0;
      head_rd_addr         <= '0;
      hist_rd_addr         <= '0;
    end else begin
      head_rd_en <= 1'b0;
      hist_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (match_req_valid) begin
            head_q               <= match_req_head_addr;
            hist_q               <= match_req_history_addr;
            match_resp_tag       <= match_req_tag;
            off_q                <= '0;
            match_resp_match_len <= '0;
            // History must lie strictly before head; anything else answers 0 without reading.
            if (match_req_history_addr >= match_req_head_addr) begin
              match_resp_valid <= 1'b1;
              state            <= RESP;
            end else begin
              head_rd_en   <= 1'b1;
              hist_rd_en   <= 1'b1;
              head_rd_addr <= match_req_head_addr;
              hist_rd_addr <= match_req_history_addr;
              state        <= READ;
            end
          end
        end
        READ: begin
          state <= CMP;
        end
        CMP: begin
          match_resp_match_len <= new_len;
          if ((eq == EQ_W'(BYTES)) && (new_len < MATCH_LEN_W'(MAX_MATCH_LEN))) begin
            off_q        <= off_q + ADDR_W'(BYTES);
            head_rd_en   <= 1'b1;
            hist_rd_en   <= 1'b1;
            head_rd_addr <= head_q + off_q + ADDR_W'(BYTES);
            hist_rd_addr <= hist_q + off_q + ADDR_W'(BYTES);
            state        <= READ;
          end else begin
            match_resp_valid <= 1'b1;
            state            <= RESP;
          end
        end
        RESP: begin
          if (match_resp_ready) begin
            match_resp_valid <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_match_pe.sv
// Directed bench for shared_match_pe with a byte-array memory model behind both read ports.
module tb_shared_match_pe;

  localparam int ADDR_W = 24, TAG_W = 5, MATCH_LEN_W = 8, MAX_MATCH_LEN = 255, BYTES = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   match_req_valid = 1'b0;
  logic                   match_req_ready;
  logic [ADDR_W-1:0]      match_req_head_addr = '0;
  logic [ADDR_W-1:0]      match_req_history_addr = '0;
  logic [TAG_W-1:0]       match_req_tag = '0;
  logic                   match_resp_valid;
  logic                   match_resp_ready = 1'b1;
  logic [TAG_W-1:0]       match_resp_tag;
  logic [MATCH_LEN_W-1:0] match_resp_match_len;
  logic                   head_rd_en;
  logic [ADDR_W-1:0]      head_rd_addr;
  logic [8*BYTES-1:0]     head_rd_data = '0;
  logic                   hist_rd_en;
  logic [ADDR_W-1:0]      hist_rd_addr;
  logic [8*BYTES-1:0]     hist_rd_data = '0;

  logic [7:0] mem [0:65535];
  int n_checks = 0;
  int n_fail = 0;
  int head_pulses = 0;
  int en_skew = 0;
  int accepts = 0;

  typedef struct {
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] hist;
    logic [TAG_W-1:0]  tag;
    int                n;
    int                exp_len;
    int                exp_lat;
  } vec_t;

  vec_t vecs [12];

  shared_match_pe #(
    .ADDR_W(ADDR_W), .TAG_W(TAG_W), .MATCH_LEN_W(MATCH_LEN_W),
    .MAX_MATCH_LEN(MAX_MATCH_LEN), .BYTES(BYTES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .match_req_valid(match_req_valid), .match_req_ready(match_req_ready),
    .match_req_head_addr(match_req_head_addr), .match_req_history_addr(match_req_history_addr),
    .match_req_tag(match_req_tag),
    .match_resp_valid(match_resp_valid), .match_resp_ready(match_resp_ready),
    .match_resp_tag(match_resp_tag), .match_resp_match_len(match_resp_match_len),
    .head_rd_en(head_rd_en), .head_rd_addr(head_rd_addr), .head_rd_data(head_rd_data),
    .hist_rd_en(hist_rd_en), .hist_rd_addr(hist_rd_addr), .hist_rd_data(hist_rd_data)
  );

  always #5 clk = ~clk;

  // One-cycle-latency read ports; the 16-bit index wraps the same way as the 24-bit address.
  always @(posedge clk) begin
    if (head_rd_en)
      for (int i = 0; i < BYTES; i++) head_rd_data[8*i +: 8] <= mem[head_rd_addr[15:0] + 16'(i)];
    if (hist_rd_en)
      for (int i = 0; i < BYTES; i++) hist_rd_data[8*i +: 8] <= mem[hist_rd_addr[15:0] + 16'(i)];
  end

  always @(posedge clk) begin
    if (head_rd_en) head_pulses <= head_pulses + 1;
    if (head_rd_en !== hist_rd_en) en_skew <= en_skew + 1;
    if (match_req_valid && match_req_ready) accepts <= accepts + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Head bytes equal history bytes for the first n positions, then differ.
  task automatic setup_mem(input logic [ADDR_W-1:0] head, input logic [ADDR_W-1:0] hist,
                           input logic [TAG_W-1:0] tag, input int n);
    int wc;
    logic [7:0] b;
    wc = (n >= 255) ? 264 : (n / 8 + 1) * 8;
    for (int i = 0; i < wc; i++) begin
      b = 8'(i * 7 + 3 + int'(tag));
      mem[hist[15:0] + 16'(i)] = b;
      mem[head[15:0] + 16'(i)] = (i < n) ? b : ~b;
    end
  endtask

  task automatic drive_req(input logic [ADDR_W-1:0] head, input logic [ADDR_W-1:0] hist,
                           input logic [TAG_W-1:0] tag);
    match_req_head_addr    = head;
    match_req_history_addr = hist;
    match_req_tag          = tag;
    match_req_valid        = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (match_req_ready) ok = 1'b1;
      @(negedge clk);
    end
    check("accept", 32'(ok), 32'd1);
  endtask

  // lat counts edges from the accepting edge to the first negedge showing resp_valid.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!match_resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("resp_seen", 32'(match_resp_valid), 32'd1);
  endtask

  initial begin
    bit ok;
    int lat, p0, a0;
    bit saw;

    vecs[0]  = '{24'h000100, 24'h000040, 5'h15,  13,  13,  5};
    vecs[1]  = '{24'h000300, 24'h000100, 5'h01,   0,   0,  3};
    vecs[2]  = '{24'h000300, 24'h000100, 5'h02,   8,   8,  5};
    vecs[3]  = '{24'h000300, 24'h000100, 5'h03,  20,  20,  7};
    vecs[4]  = '{24'h000200, 24'h000200, 5'h04,  -1,   0,  1};
    vecs[5]  = '{24'h000200, 24'h000201, 5'h05,  -1,   0,  1};
    vecs[6]  = '{24'h000800, 24'h000500, 5'h06,   7,   7,  3};
    vecs[7]  = '{24'h000900, 24'h000100, 5'h07, 300, 255, 65};
    vecs[8]  = '{24'h000A00, 24'h000800, 5'h08, 254, 254, 65};
    vecs[9]  = '{24'h000A00, 24'h000800, 5'h09, 255, 255, 65};
    vecs[10] = '{24'hFFFFFC, 24'h008000, 5'h0A,  10,  10,  5};
    vecs[11] = '{24'h000300, 24'h000100, 5'h0B,  16,  16,  7};

    #1;
    check("reset_outputs", {29'd0, match_req_ready, match_resp_valid, head_rd_en | hist_rd_en}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 32'(match_req_ready), 32'd1);
    @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      if (vecs[v].n >= 0) setup_mem(vecs[v].head, vecs[v].hist, vecs[v].tag, vecs[v].n);
      p0 = head_pulses;
      match_resp_ready = 1'b1;
      drive_req(vecs[v].head, vecs[v].hist, vecs[v].tag);
      wait_accept(ok);
      match_req_valid = 1'b0;
      if (ok) begin
        wait_resp(lat);
        check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
        check($sformatf("v%0d_len", v), 32'(match_resp_match_len), 32'(vecs[v].exp_len));
        check($sformatf("v%0d_tag", v), 32'(match_resp_tag), 32'(vecs[v].tag));
        @(negedge clk);
        check($sformatf("v%0d_post_handshake", v), {30'd0, match_resp_valid, match_req_ready}, 32'd1);
        check($sformatf("v%0d_rd_pulses", v), 32'(head_pulses - p0), 32'((vecs[v].exp_lat - 1) / 2));
      end
    end

    // Uniform memory: 31 full beats plus a final beat clipped to 7 bytes.
    for (int i = 0; i < 16'h0500; i++) mem[i] = 8'hAA;
    p0 = head_pulses;
    drive_req(24'h000400, 24'h000000, 5'h11);
    wait_accept(ok);
    match_req_valid = 1'b0;
    wait_resp(lat);
    check("aa_len", 32'(match_resp_match_len), 32'd255);
    check("aa_tag", 32'(match_resp_tag), 32'h11);
    check("aa_latency", 32'(lat), 32'd65);
    @(negedge clk);
    check("aa_rd_pulses", 32'(head_pulses - p0), 32'd32);

    // Response backpressure: everything must hold while resp_ready is low.
    setup_mem(24'h000600, 24'h000500, 5'h0C, 1);
    match_resp_ready = 1'b0;
    drive_req(24'h000600, 24'h000500, 5'h0C);
    wait_accept(ok);
    match_req_valid = 1'b0;
    wait_resp(lat);
    check("bp_latency", 32'(lat), 32'd3);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold%0d", k),
            {17'd0, match_resp_valid, match_req_ready, match_resp_tag, match_resp_match_len},
            {17'd0, 1'b1, 1'b0, 5'h0C, 8'd1});
      @(negedge clk);
    end
    match_resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {30'd0, match_resp_valid, match_req_ready}, 32'd1);

    // Back-to-back with req_valid held high throughout; only IDLE may accept.
    setup_mem(24'h001100, 24'h001000, 5'h01, 0);
    setup_mem(24'h001300, 24'h001200, 5'h02, 8);
    setup_mem(24'h001500, 24'h001400, 5'h03, 20);
    a0 = accepts;
    drive_req(24'h001100, 24'h001000, 5'h01);
    wait_accept(ok);
    drive_req(24'h001300, 24'h001200, 5'h02);
    wait_resp(lat);
    check("b2b_1", {19'd0, match_resp_tag, match_resp_match_len}, {19'd0, 5'h01, 8'd0});
    @(negedge clk);
    wait_accept(ok);
    drive_req(24'h001500, 24'h001400, 5'h03);
    wait_resp(lat);
    check("b2b_2", {19'd0, match_resp_tag, match_resp_match_len}, {19'd0, 5'h02, 8'd8});
    @(negedge clk);
    wait_accept(ok);
    match_req_valid = 1'b0;
    wait_resp(lat);
    check("b2b_3", {19'd0, match_resp_tag, match_resp_match_len}, {19'd0, 5'h03, 8'd20});
    @(negedge clk);
    check("b2b_accepts", 32'(accepts - a0), 32'd3);

    // Reset during the compare of a multi-beat match discards the request.
    setup_mem(24'h000300, 24'h000100, 5'h1A, 20);
    drive_req(24'h000300, 24'h000100, 5'h1A);
    wait_accept(ok);
    match_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_outputs", {29'd0, match_req_ready, match_resp_valid, head_rd_en | hist_rd_en}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_hold%0d", k), {30'd0, match_resp_valid, head_rd_en | hist_rd_en}, 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", 32'(match_req_ready), 32'd1);
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      saw = saw | match_resp_valid;
    end
    check("rst_no_resp", 32'(saw), 32'd0);
    setup_mem(24'h000300, 24'h000100, 5'h1B, 20);
    drive_req(24'h000300, 24'h000100, 5'h1B);
    wait_accept(ok);
    match_req_valid = 1'b0;
    wait_resp(lat);
    check("rst_next_len", 32'(match_resp_match_len), 32'd20);
    check("rst_next_tag", 32'(match_resp_tag), 32'h1B);
    check("rst_next_latency", 32'(lat), 32'd7);
    @(negedge clk);

    check("en_sync", 32'(en_skew), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/shared_match_pe.md
Name: shared_match_pe

Overview:
- Match engine that serves one match request from the mesh adapter: compares the bytes at `head_addr` with the bytes at `history_addr`.
- Returns the length of the common prefix together with the request tag.
- Sits directly downstream of the mesh adapter's `match_req_*` channel and upstream of its `match_resp_*` channel.
- Reads history data through two fixed-latency read ports, one per byte stream.

Parameters:
- ADDR_W, 24, byte address width (equals `ADDR_WIDTH`).
- TAG_W, 5, tag width (`NUM_JOB_PE_LOG2+LAZY_LEN_LOG2`).
- MATCH_LEN_W, 8, match-length width (`MATCH_LEN_WIDTH`).
- MAX_MATCH_LEN, 255, cap on the reported length; must be less than 2^MATCH_LEN_W.
- BYTES, 8, bytes compared per beat; power of two.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- match_req_valid  in  1  request valid.
- match_req_ready  out  1  request accepted when valid&&ready.
- match_req_head_addr  in  ADDR_W  current (newer) position.
- match_req_history_addr  in  ADDR_W  candidate (older) position.
- match_req_tag  in  TAG_W  opaque tag.
- match_resp_valid  out  1  response valid.
- match_resp_ready  in  1  response consumed when valid&&ready.
- match_resp_tag  out  TAG_W  tag of the accepted request.
- match_resp_match_len  out  MATCH_LEN_W  match length.
- head_rd_en  out  1  head read strobe.
- head_rd_addr  out  ADDR_W  byte address for the head read.
- head_rd_data  in  8*BYTES  head read data; byte i in bits [8i+7:8i] is address+i; valid exactly 1 cycle after head_rd_en.
- hist_rd_en  out  1  history read strobe.
- hist_rd_addr  out  ADDR_W  byte address for the history read.
- hist_rd_data  in  8*BYTES  history read data; same format and latency as head_rd_data.

Behaviour:
- Reset: state=IDLE; match_resp_valid=0, head_rd_en=0, hist_rd_en=0.
  - Address, tag and length registers reset to 0.
  - match_req_ready=0 while rst_n is low.
- match_req_ready is 1 exactly when state==IDLE (combinational from state).
- Registered outputs: rd_en/rd_addr, all resp_* outputs.
- FSM states: IDLE, READ, CMP, RESP.
- IDLE, on accept:
  - Latch head, hist, tag.
  - Clear off and len to 0.
  - If hist_addr >= head_addr: invalid request; go to RESP with len=0 and issue no reads.
  - Otherwise go to READ.
- READ:
  - Pulse head_rd_en and hist_rd_en for one cycle, with addresses head+off and hist+off.
  - Address arithmetic wraps mod 2^ADDR_W.
  - Go to CMP.
- CMP:
  - eq = count of consecutive equal bytes starting at byte 0, range 0..BYTES.
  - rem = MAX_MATCH_LEN - len; add = min(eq, rem); len += add.
  - If eq==BYTES and len+add < MAX_MATCH_LEN: off += BYTES, go to READ.
  - Otherwise go to RESP.
- RESP:
  - Hold match_resp_valid=1 with stable tag and len until match_resp_ready.
  - On the handshake cycle, deassert valid and go to IDLE.
  - A new request can be accepted at the earliest one cycle after the handshake.
- Latency: request accepted in cycle T → first rd_en in T+1 → compare in T+2. Each additional beat adds 2 cycles. Earliest resp_valid is T+3 (for a 1-beat mismatch).
- Overlapping ranges (head - hist < BYTES) need no special handling; history memory is static while a request is in flight.
- len never exceeds MAX_MATCH_LEN; a partial final beat is clipped by rem.
- match_resp_ready while resp_valid=0 is ignored.
- match_req_valid while not IDLE is ignored; there is no queuing.
- Reset asserted mid-operation:
  - The in-flight request is discarded, with no response.
  - Read data returning after reset is ignored.
  - After release the block is IDLE with ready=1.

Test Plan:
- Head 0x100 and hist 0x040 equal for 13 bytes, byte 13 differs; tag=0x15, accepted at T → reads at off 0 and off 8, resp_valid at T+5, len=13, tag=0x15.
- Memory all 0xAA, head=0x400, hist=0x000 → 32 beats, len=255; the last beat adds only 7; exactly 32 head_rd_en pulses.
- hist_addr=0x200, head_addr=0x200 (also try hist=0x201) → len=0, resp_valid at T+1, no rd_en pulse ever.
- 1-byte match with match_resp_ready held low 5 cycles after resp_valid → tag/len stable throughout, match_req_ready=0 throughout; ready=1 the cycle after the handshake.
- Back-to-back requests with tags 1,2,3 and lens 0,8,20 → responses in order with correct lens; no request accepted outside IDLE.
- rst_n pulsed low during CMP of a multi-beat match → no response; rd_en=0 while in reset; the next request after release returns the correct len.
